// File: rtl/dist_ram_pkg.sv
// Shared constants, state encoding and slice helper for the banked distributed RAM.
// Pure declarations; no timing or flow-control behaviour of its own.
package dist_ram_pkg;

  localparam int DEF_RAM_WIDTH     = 16;
  localparam int DEF_RAM_ADDR_BITS = 10;
  localparam int DEF_NUM_BANKS     = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // LSB position of bank b inside the flattened all-banks word
  function automatic int bank_lsb(input int b, input int width);
    return b * width;
  endfunction

endpackage

// File: rtl/dist_ram_bank.sv
// One distributed-RAM bank: synchronous write, asynchronous (combinational) read.
// Read is zero-latency; no flow control, the caller qualifies the write strobe.
module dist_ram_bank #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dist_ram_banked.sv
// Multi-bank RAM, one-bank write / all-bank read, 1-cycle registered read with valid, zeroing sweep.
// ready=0 during sweep drops reads/writes; DIST_RAM_BYPASS_EN selects write-first on same-address collisions.
module dist_ram_banked
  import dist_ram_pkg::*;
#(
  parameter  int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter  int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter  int NUM_BANKS     = DEF_NUM_BANKS,
  localparam int BANK_BITS     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clear_start,
  output logic                           ready,
  input  logic                           write_enable,
  input  logic [BANK_BITS-1:0]           write_bank,
  input  logic [RAM_ADDR_BITS-1:0]       write_address,
  input  logic [RAM_WIDTH-1:0]           input_data,
  input  logic                           read_enable,
  input  logic [RAM_ADDR_BITS-1:0]       read_address,
  output logic [NUM_BANKS*RAM_WIDTH-1:0] output_data,
  output logic                           read_valid
);

  localparam logic [RAM_ADDR_BITS-1:0] CNT_LAST = {RAM_ADDR_BITS{1'b1}};

  state_t                         state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]       cnt_q, cnt_d;
  logic [NUM_BANKS*RAM_WIDTH-1:0] rdata_q, rdata_d;
  logic                           rvld_q, rvld_d;
  logic [NUM_BANKS*RAM_WIDTH-1:0] rd_raw;
  logic                           clearing, wr_ok, rd_ok;

  assign ready    = (state_q == ST_READY);
  assign clearing = (state_q == ST_CLEAR);
  // Holding reset low must not let a stray strobe touch memory or the read register.
  assign wr_ok    = reset_n & ready & write_enable;
  assign rd_ok    = reset_n & ready & read_enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + RAM_ADDR_BITS'(1);
        end
      end
      default: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                     bank_we;
    logic [RAM_ADDR_BITS-1:0] bank_waddr;
    logic [RAM_WIDTH-1:0]     bank_wdata;
    logic [RAM_WIDTH-1:0]     bank_rdata;
    logic                     bank_sel;

    // Out-of-range bank indices never match, so such writes land nowhere.
    assign bank_sel   = (write_bank == BANK_BITS'(b));
    assign bank_we    = reset_n & (clearing | (wr_ok & bank_sel));
    assign bank_waddr = clearing ? cnt_q : write_address;
    assign bank_wdata = clearing ? '0 : input_data;

    dist_ram_bank #(
      .WIDTH     (RAM_WIDTH),
      .ADDR_BITS (RAM_ADDR_BITS)
    ) u_bank (
      .clock (clock),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (read_address),
      .rdata (bank_rdata)
    );

`ifdef DIST_RAM_BYPASS_EN
    assign rd_raw[bank_lsb(b, RAM_WIDTH) +: RAM_WIDTH] =
      (wr_ok && bank_sel && (write_address == read_address)) ? input_data : bank_rdata;
`else
    assign rd_raw[bank_lsb(b, RAM_WIDTH) +: RAM_WIDTH] = bank_rdata;
`endif
  end

  always_comb begin
    rvld_d  = rd_ok;
    rdata_d = rd_ok ? rd_raw : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  assign output_data = rdata_q;
  assign read_valid  = rvld_q;

endmodule

// File: doc/dist_ram_banked.md
# dist_ram_banked

Parametrised multi-bank distributed RAM for feature-map storage: NUM_BANKS independent banks share one address space, are written one bank per cycle and read all-banks-in-parallel at a single address. Adds a registered read with valid, a self-clearing sweep after reset or on request, and optional write-to-read forwarding. Sits between the layer write-back path and the convolution engine's channel-parallel operand fetch.

## Interface
- RAM_WIDTH, 16, bits per word per bank
- RAM_ADDR_BITS, 10, address bits; depth = 2**RAM_ADDR_BITS
- NUM_BANKS, 4, bank (channel) count, ≥1
- BANK_BITS, $clog2(NUM_BANKS) (min 1), derived, not overridden
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- clear_start  in  1  request a zeroing sweep of all banks
- ready  out  1  high when idle and accepting reads/writes
- write_enable  in  1  write strobe
- write_bank  in  BANK_BITS  target bank
- write_address  in  RAM_ADDR_BITS  write address
- input_data  in  RAM_WIDTH  write data
- read_enable  in  1  read strobe
- read_address  in  RAM_ADDR_BITS  read address, all banks
- output_data  out  NUM_BANKS*RAM_WIDTH  bank b at bits [b*RAM_WIDTH +: RAM_WIDTH]
- read_valid  out  1  output_data valid this cycle

## Operation
- States: CLEAR, READY. Reset enters CLEAR with sweep counter 0.
- CLEAR: each cycle write 0 to counter address in all banks, increment; at counter = 2**RAM_ADDR_BITS−1 write then go READY. ready = 0 throughout.
- READY: ready = 1. clear_start = 1 → CLEAR, counter 0; clear_start in CLEAR ignored.
- Writes honoured only when ready = 1; write_bank ≥ NUM_BANKS ignored (no bank written).
- Reads honoured only when ready = 1; read_enable while ready = 0 produces no read_valid.
- Read in same cycle as clear_start is honoured (state still READY).
- Read-write same address same cycle: see Configuration.
- Counter is RAM_ADDR_BITS+0 wide and never wraps past terminal value; no arithmetic overflow otherwise.

## Timing
- Reset values: ready 0, read_valid 0, output_data 0, state CLEAR, counter 0.
- Clear sweep: 2**RAM_ADDR_BITS cycles; ready rises the cycle after final clear write (first cycle after reset deassert counts as sweep cycle 0).
- Write: memory updated at the clock edge where write_enable = 1 and ready = 1; visible to reads issued next cycle.
- Read latency 1: read_enable at edge t → output_data, read_valid at t+1; read_valid is a single-cycle pulse per accepted read; output_data holds last value when read_valid = 0.
- Back-to-back reads every cycle supported, full throughput.
- reset_n low mid-sweep or mid-read: restart sweep, read_valid 0 next cycle, no partial data.

## Configuration
- DIST_RAM_BYPASS_EN defined: same-cycle read and write to same address → output_data slice for write_bank carries input_data (write-first); other banks return stored data.
- Undefined: read-first; output_data returns pre-write contents for all banks, new value visible from next read.

## Structure
- Package dist_ram_pkg: state enum (CLEAR, READY), default parameter constants, bank-slice helper function.
- Sub-module dist_ram_bank: one distributed bank, sync write, async read, ram_style "distributed"; instantiated NUM_BANKS times via generate. Top holds FSM, counter, read register and bypass mux.

## Test plan
- Reset deassert, RAM_ADDR_BITS=4 → ready low 16 cycles, high cycle 17; read all 16 addresses → all zero, read_valid one cycle after each read_enable.
- Write 0xA5A5 bank 2 addr 5, next cycle read addr 5 → slice 2 = 0xA5A5, slices 0,1,3 = 0.
- Same-cycle write 0x1234 bank 0 addr 7 and read addr 7 (old 0x0000) → with DIST_RAM_BYPASS_EN slice 0 = 0x1234; without, 0x0000, then 0x1234 on next read.
- Fill addresses, pulse clear_start, write during sweep → ready low 2**RAM_ADDR_BITS cycles, writes dropped, all reads return 0 afterward.
- reset_n low for 1 cycle at sweep count 8 → sweep restarts from 0, ready asserts 2**RAM_ADDR_BITS cycles after release.
- NUM_BANKS=3, write_bank=3 with 0xFFFF → no bank changes; continuous reads every cycle, random addresses → read_valid high every cycle, data matches model.
